// File: rtl/alu_pkg.sv
// Shared ALU_32-Bit definitions: FSM state encoding, default width and the
// last shift-add iteration index.
package alu_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ITER_LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_seq_32.sv
// Sequential signed multiply-accumulate Y = S*T + A (64-bit result), computed
// by sign-magnitude shift-add over WIDTH cycles with a start/done handshake.
module mac_seq_32 #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             busy,
  output logic             done,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);
  import alu_pkg::*;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH:0]        r_mplier;
  logic [2*WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]      r_a;
  logic                  r_sign;
  logic [CNT_W-1:0]      r_cnt;

  logic [WIDTH:0]        w_s_ext;
  logic [WIDTH:0]        w_t_ext;
  logic [WIDTH:0]        w_s_mag;
  logic [WIDTH:0]        w_t_mag;
  logic [2*WIDTH-1:0]    w_acc_signed;
  logic [2*WIDTH-1:0]    w_res;
  logic                  w_last_iter;

  // One extra bit keeps |-2^(WIDTH-1)| representable.
  assign w_s_ext = {S[WIDTH-1], S};
  assign w_t_ext = {T[WIDTH-1], T};
  assign w_s_mag = w_s_ext[WIDTH] ? -w_s_ext : w_s_ext;
  assign w_t_mag = w_t_ext[WIDTH] ? -w_t_ext : w_t_ext;

  assign w_acc_signed = r_sign ? -r_acc : r_acc;
  assign w_res        = w_acc_signed + {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_last_iter  = (r_cnt == CNT_W'(ITER_LAST));

  assign busy = (r_state != IDLE);
  assign C    = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_last_iter) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      Y_hi     <= '0;
      Y_lo     <= '0;
      done     <= 1'b0;
      V        <= 1'b0;
      N        <= 1'b0;
      Z        <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_s_mag};
            r_mplier <= w_t_mag;
            r_a      <= A;
            r_sign   <= S[WIDTH-1] ^ T[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        FIX: begin
          Y_hi <= w_res[2*WIDTH-1:WIDTH];
          Y_lo <= w_res[WIDTH-1:0];
          V    <= (w_res[2*WIDTH-1:WIDTH] != {WIDTH{w_res[WIDTH-1]}});
          N    <= w_res[2*WIDTH-1];
          Z    <= (w_res == '0);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
